// File: rtl/minesweeper_reveal_ctrl.sv
// Flood-fill reveal controller for a 16x16 minesweeper board held in an
// external synchronous-read memory. Cells to uncover go through an internal
// 256-entry FIFO; the queued bit in each cell stops a cell being pushed twice.
module minesweeper_reveal_ctrl #(
  parameter int CELL_W = 7,
  parameter int GRID_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        startPos,
  output logic              busy,
  output logic              done,
  output logic              hitBomb,
  output logic [8:0]        revealedCount,
  output logic [7:0]        memAddr,
  output logic              memRe,
  input  logic [0:CELL_W-1] memDin,
  output logic              memWe,
  output logic [0:CELL_W-1] memDout,
  output logic              qOverflow
);

  localparam int B_BOMB = 0;
  localparam int B_FLAG = 4;
  localparam int B_COV  = 5;
  localparam int B_Q    = 6;
  localparam logic [3:0] EDGE_HI = 4'(GRID_W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_POP_WAIT, S_CHECK, S_NB_SEL,
    S_NB_RD, S_NB_WAIT, S_NB_CHK, S_DONE
  } state_t;

  state_t            state, next;
  logic [7:0]        fifo [256];
  logic [7:0]        rd_ptr, wr_ptr;
  logic [8:0]        count;
  logic [3:0]        k;
  logic [7:0]        cur_pos, nb_pos;
  logic [0:CELL_W-1] cur_cell, nb_cell;
  logic              hit, ovf;
  logic [8:0]        rc;

  logic              push, pop, flush, k_clr, k_inc, rc_inc, set_hit, clr_result;
  logic [7:0]        push_data;
  logic              push_ok;

  // Neighbour k lies off the board (no row wrap, no 8-bit address wrap)
  function automatic logic nb_skip(input logic [7:0] pos, input logic [2:0] kk);
    logic top, bot, left, right;
    top   = (pos[7:4] == 4'd0);
    bot   = (pos[7:4] == EDGE_HI);
    left  = (pos[3:0] == 4'd0);
    right = (pos[3:0] == EDGE_HI);
    case (kk)
      3'd0: return top | left;
      3'd1: return top;
      3'd2: return top | right;
      3'd3: return left;
      3'd4: return right;
      3'd5: return bot | left;
      3'd6: return bot;
      default: return bot | right;
    endcase
  endfunction

  // Address of neighbour k in NW,N,NE,W,E,SW,S,SE order
  function automatic logic [7:0] nb_addr(input logic [7:0] pos, input logic [2:0] kk);
    case (kk)
      3'd0: return pos - 8'(GRID_W + 1);
      3'd1: return pos - 8'(GRID_W);
      3'd2: return pos - 8'(GRID_W - 1);
      3'd3: return pos - 8'd1;
      3'd4: return pos + 8'd1;
      3'd5: return pos + 8'(GRID_W - 1);
      3'd6: return pos + 8'(GRID_W);
      default: return pos + 8'(GRID_W + 1);
    endcase
  endfunction

  assign push_ok       = push && (count != 9'd256);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign hitBomb       = hit;
  assign revealedCount = rc;
  assign qOverflow     = ovf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  // Next-state, memory strobes and queue/control requests
  always_comb begin
    next       = state;
    push       = 1'b0;
    push_data  = 8'd0;
    pop        = 1'b0;
    flush      = 1'b0;
    k_clr      = 1'b0;
    k_inc      = 1'b0;
    rc_inc     = 1'b0;
    set_hit    = 1'b0;
    clr_result = 1'b0;
    memAddr    = 8'd0;
    memRe      = 1'b0;
    memWe      = 1'b0;
    memDout    = '0;
    case (state)
      S_IDLE: if (start) begin
        push       = 1'b1;
        push_data  = startPos;
        clr_result = 1'b1;
        next       = S_POP;
      end
      S_POP: if (count == 9'd0) next = S_DONE;
      else begin
        pop     = 1'b1;
        memAddr = fifo[rd_ptr];
        memRe   = 1'b1;
        next    = S_POP_WAIT;
      end
      S_POP_WAIT: next = S_CHECK;
      S_CHECK: if (!cur_cell[B_COV] || cur_cell[B_FLAG]) next = S_POP;
      else begin
        memWe          = 1'b1;
        memAddr        = cur_pos;
        memDout        = cur_cell;
        memDout[B_COV] = 1'b0;
        memDout[B_Q]   = 1'b0;
        rc_inc         = 1'b1;
        if (cur_cell[B_BOMB]) begin
          set_hit = 1'b1;
          flush   = 1'b1;
          next    = S_DONE;
        end else if (cur_cell[1:3] == 3'd0) begin
          k_clr = 1'b1;
          next  = S_NB_SEL;
        end else begin
          next = S_POP;
        end
      end
      S_NB_SEL: if (k == 4'd8) next = S_POP;
      else if (nb_skip(cur_pos, k[2:0])) k_inc = 1'b1;
      else next = S_NB_RD;
      S_NB_RD: begin
        memAddr = nb_pos;
        memRe   = 1'b1;
        next    = S_NB_WAIT;
      end
      S_NB_WAIT: next = S_NB_CHK;
      S_NB_CHK: begin
        if (nb_cell[B_COV] && !nb_cell[B_FLAG] && !nb_cell[B_Q] && !nb_cell[B_BOMB]) begin
          memWe        = 1'b1;
          memAddr      = nb_pos;
          memDout      = nb_cell;
          memDout[B_Q] = 1'b1;
          push         = 1'b1;
          push_data    = nb_pos;
        end
        k_inc = 1'b1;
        next  = S_NB_SEL;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Queue pointers, neighbour index and reveal result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 8'd0;
      wr_ptr <= 8'd0;
      count  <= 9'd0;
      k      <= 4'd0;
      hit    <= 1'b0;
      rc     <= 9'd0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        count  <= 9'd0;
        rd_ptr <= wr_ptr;
      end else if (push) begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 8'd1;
          count  <= count + 9'd1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + 8'd1;
        count  <= count - 9'd1;
      end
      if (k_clr)      k <= 4'd0;
      else if (k_inc) k <= k + 4'd1;
      if (clr_result) begin
        rc  <= 9'd0;
        hit <= 1'b0;
      end else begin
        if (rc_inc)  rc  <= rc + 9'd1;
        if (set_hit) hit <= 1'b1;
      end
    end
  end

  // Datapath captures: queue storage, current/neighbour position and cell
  always_ff @(posedge clk) begin
    if (push_ok)              fifo[wr_ptr] <= push_data;
    if (pop)                  cur_pos  <= fifo[rd_ptr];
    if (state == S_POP_WAIT)  cur_cell <= memDin;
    if (state == S_NB_SEL)    nb_pos   <= nb_addr(cur_pos, k[2:0]);
    if (state == S_NB_WAIT)   nb_cell  <= memDin;
  end

endmodule

// File: tb/tb_minesweeper_reveal_ctrl.sv
// Self-checking bench: table-driven board scenarios, hand-written start/reset
// sequences and randomized boards against a grid-level flood-fill model.
module tb_minesweeper_reveal_ctrl;

  localparam int K_EMPTY = 0, K_NUM = 1, K_BOMB0 = 2, K_FLAG = 3,
                 K_UNCOV = 4, K_EDGE = 5, K_CORNER = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] startPos = 8'd0;
  logic       busy, done, hitBomb, memRe, memWe, qOverflow;
  logic [8:0] revealedCount;
  logic [7:0] memAddr;
  logic [0:6] memDin = 7'd0;
  logic [0:6] memDout;

  logic [0:6] board [256];
  logic [0:6] stage [256];
  logic [0:6] mdl_board [256];
  int         rd_stamp [256];
  int         mdl_rc;
  int         mdl_hit;
  logic       load_go = 1'b0;
  int         run_id = 0;
  int         rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;
  int         n_cmp = 0, n_fail = 0;

  typedef struct {
    int kind;
    int start;
    int rc;
    int hit;
    int reads;
    int writes;
  } vec_t;
  vec_t vecs [8];

  minesweeper_reveal_ctrl #(.CELL_W(7), .GRID_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .startPos(startPos),
    .busy(busy), .done(done), .hitBomb(hitBomb), .revealedCount(revealedCount),
    .memAddr(memAddr), .memRe(memRe), .memDin(memDin), .memWe(memWe),
    .memDout(memDout), .qOverflow(qOverflow)
  );

  always #5 clk = ~clk;

  // Board memory with one-cycle read latency, plus activity monitors
  always @(posedge clk) begin
    if (load_go) begin
      for (int i = 0; i < 256; i++) board[i] <= stage[i];
    end else if (memWe) begin
      board[memAddr] <= memDout;
    end
    if (memRe) begin
      memDin <= board[memAddr];
      rd_cnt <= rd_cnt + 1;
      rd_stamp[memAddr] <= run_id;
    end
    if (memWe) wr_cnt <= wr_cnt + 1;
    if (memWe && memRe) both_cnt <= both_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [0:6] mk(input bit b, input int adj, input bit f, input bit c);
    logic [0:6] v;
    v[0]   = b;
    v[1:3] = 3'(adj);
    v[4]   = f;
    v[5]   = c;
    v[6]   = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        K_NUM:                      stage[i] = mk(0, 2, 0, 1);
        K_BOMB0, K_EDGE, K_CORNER:  stage[i] = mk(0, 1, 0, 1);
        default:                    stage[i] = mk(0, 0, 0, 1);
      endcase
    end
    case (kind)
      K_BOMB0:  stage[0]     = mk(1, 0, 0, 1);
      K_FLAG:   stage[8'h33] = mk(0, 0, 1, 1);
      K_UNCOV:  stage[8'h44] = mk(0, 0, 0, 0);
      K_EDGE:   stage[8'h0F] = mk(0, 0, 0, 1);
      K_CORNER: stage[8'h00] = mk(0, 0, 0, 1);
      default: ;
    endcase
  endtask

  // Random board: bombs with true neighbour counts (capped at 7), some flags
  // and some already-uncovered cells
  task automatic build_rand();
    bit bomb [256];
    for (int i = 0; i < 256; i++) bomb[i] = ($urandom_range(0, 99) < 12);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              if (bomb[(r + dr) * 16 + c + dc]) n++;
        if (n > 7) n = 7;
        stage[r * 16 + c] = mk(bomb[r * 16 + c], n, ($urandom_range(0, 99) < 4),
                               ($urandom_range(0, 99) < 95));
      end
  endtask

  // Reference: breadth-first flood over the 2-D grid
  task automatic run_model(input int s);
    int  q [$];
    bit  inq [256];
    logic [0:6] c;
    for (int i = 0; i < 256; i++) begin
      mdl_board[i] = stage[i];
      inq[i] = 1'b0;
    end
    mdl_rc  = 0;
    mdl_hit = 0;
    c = stage[s];
    if (!c[5] || c[4]) return;
    if (c[0]) begin
      mdl_board[s][5] = 1'b0;
      mdl_board[s][6] = 1'b0;
      mdl_rc  = 1;
      mdl_hit = 1;
      return;
    end
    q.push_back(s);
    inq[s] = 1'b1;
    while (q.size() > 0) begin
      int p, r, cc;
      p = q.pop_front();
      mdl_board[p][5] = 1'b0;
      mdl_board[p][6] = 1'b0;
      mdl_rc++;
      r  = p / 16;
      cc = p % 16;
      if (stage[p][1:3] == 3'd0)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && cc + dc >= 0 && cc + dc < 16) begin
              int n;
              logic [0:6] nc;
              n  = (r + dr) * 16 + cc + dc;
              nc = mdl_board[n];
              if (nc[5] && !nc[4] && !nc[6] && !nc[0] && !inq[n]) begin
                inq[n] = 1'b1;
                q.push_back(n);
              end
            end
    end
  endtask

  task automatic load();
    @(negedge clk);
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic pulse_start(input int s);
    run_id++;
    startPos = 8'(s);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int rc_o, output int hit_o);
    bit ok;
    ok = 1'b0;
    rc_o = -1;
    hit_o = -1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        ok = 1'b1;
        rc_o = revealedCount;
        hit_o = hitBomb;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, ok, 1);
    @(negedge clk);
  endtask

  task automatic chk_board(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (board[i] !== mdl_board[i]) bad++;
    chk({nm, "_board_cells_wrong"}, bad, 0);
  endtask

  initial begin
    int rc, hit, r0, w0, d0;
    vecs[0] = '{K_NUM,    8'h77, 1,   0, 1,    1};
    vecs[1] = '{K_BOMB0,  8'h00, 1,   1, 1,    1};
    vecs[2] = '{K_FLAG,   8'h33, 0,   0, 1,    0};
    vecs[3] = '{K_UNCOV,  8'h44, 0,   0, 1,    0};
    vecs[4] = '{K_EDGE,   8'h0F, 4,   0, 7,    7};
    vecs[5] = '{K_CORNER, 8'h00, 4,   0, 7,    7};
    vecs[6] = '{K_EMPTY,  8'h00, 256, 0, 2116, 511};
    vecs[7] = '{K_EMPTY,  8'h88, 256, 0, 2116, 511};
    for (int i = 0; i < 256; i++) rd_stamp[i] = 0;

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_outputs", {hitBomb, qOverflow, memRe, memWe, revealedCount, memAddr, memDout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven scenarios
    foreach (vecs[v]) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      build(vecs[v].kind);
      load();
      run_model(vecs[v].start);
      r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      pulse_start(vecs[v].start);
      wait_done(nm, rc, hit);
      chk({nm, "_revealedCount"}, rc, vecs[v].rc);
      chk({nm, "_hitBomb"}, hit, vecs[v].hit);
      chk({nm, "_reads"}, rd_cnt - r0, vecs[v].reads);
      chk({nm, "_writes"}, wr_cnt - w0, vecs[v].writes);
      chk({nm, "_done_pulses"}, done_cnt - d0, 1);
      chk({nm, "_result_hold"}, {hitBomb, revealedCount}, {vecs[v].hit[0], 9'(vecs[v].rc)});
      chk_board(nm);
      if (vecs[v].kind == K_EDGE) begin
        chk("edge_read_10", rd_stamp[8'h10] == run_id, 0);
        chk("edge_read_00", rd_stamp[8'h00] == run_id, 0);
        chk("edge_read_0E", rd_stamp[8'h0E] == run_id, 1);
        chk("edge_read_1E", rd_stamp[8'h1E] == run_id, 1);
        chk("edge_read_1F", rd_stamp[8'h1F] == run_id, 1);
      end
      if (vecs[v].kind == K_EMPTY) chk({nm, "_qOverflow"}, qOverflow, 0);
    end

    // start while busy is ignored
    build(K_EMPTY);
    load();
    run_model(0);
    d0 = done_cnt;
    pulse_start(0);
    repeat (30) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    startPos = 8'h88;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", rc, hit);
    chk("busy_start_rc", rc, 256);
    chk("busy_start_done_pulses", done_cnt - d0, 1);
    repeat (5) @(negedge clk);
    chk("busy_start_idle_after", {busy, done}, 0);
    chk_board("busy_start");

    // Asynchronous reset in the middle of a fill
    build(K_EMPTY);
    load();
    pulse_start(8'h88);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_outputs", {done, hitBomb, memRe, memWe, revealedCount, memAddr, memDout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    build(K_NUM);
    load();
    run_model(8'h77);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_start(8'h77);
    wait_done("after_reset", rc, hit);
    chk("after_reset_rc", rc, 1);
    chk("after_reset_reads", rd_cnt - r0, 1);
    chk("after_reset_writes", wr_cnt - w0, 1);
    chk_board("after_reset");

    // Randomized boards against the flood-fill model
    for (int t = 0; t < 6; t++) begin
      int s;
      string nm;
      nm = $sformatf("rand%0d", t);
      build_rand();
      s = $urandom_range(0, 255);
      if (t < 4)
        for (int tries = 0; tries < 200; tries++) begin
          s = $urandom_range(0, 255);
          if (stage[s] == mk(0, 0, 0, 1)) break;
        end
      load();
      run_model(s);
      pulse_start(s);
      wait_done(nm, rc, hit);
      chk({nm, "_revealedCount"}, rc, mdl_rc);
      chk({nm, "_hitBomb"}, hit, mdl_hit);
      chk_board(nm);
    end

    chk("final_qOverflow", qOverflow, 0);
    chk("we_re_overlap_cycles", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
